// File: rtl/hwag_angle_gen.sv
// Crank angle generator: interpolates 2^STEPS_LOG2 angle steps between qualified
// tooth edges, stretching the interval after GAP_TOOTH to span three tooth spaces.
module hwag_angle_gen #(
  parameter int PCNT_WIDTH  = 24,
  parameter int TCNT_WIDTH  = 6,
  parameter int STEPS_LOG2  = 6,
  parameter int GAP_TOOTH   = 57,
  parameter int ANGLE_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tooth_edge,
  input  logic                   hwag_start,
  input  logic [TCNT_WIDTH-1:0]  tooth_num,
  input  logic [PCNT_WIDTH-1:0]  tooth_period,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic                   angle_tick,
  output logic                   angle_valid,
  output logic                   angle_stall
);

  localparam int STEPS     = 1 << STEPS_LOG2;
  localparam int SUB_WIDTH = STEPS_LOG2 + 2;

  localparam logic [SUB_WIDTH-1:0] LIMIT_NORMAL = SUB_WIDTH'(STEPS - 1);
  localparam logic [SUB_WIDTH-1:0] LIMIT_GAP    = SUB_WIDTH'(3 * STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

  state_e                  state_q, state_d;
  logic [ANGLE_WIDTH-1:0]  angle_q, angle_d;
  logic                    tick_q, tick_d;
  logic [SUB_WIDTH-1:0]    sub_q, sub_d;
  logic [SUB_WIDTH-1:0]    limit_q, limit_d;
  logic [PCNT_WIDTH-1:0]   step_period_q, step_period_d;
  logic [PCNT_WIDTH-1:0]   step_cnt_q, step_cnt_d;

  logic [TCNT_WIDTH+STEPS_LOG2-1:0] base_full;
  logic [PCNT_WIDTH-1:0]            period_scaled;
  logic                             step_expire;
  logic                             sub_last;

  assign base_full     = {tooth_num, {STEPS_LOG2{1'b0}}};
  assign period_scaled = tooth_period >> STEPS_LOG2;
  assign step_expire   = (state_q == RUN)
                      && (step_cnt_q == step_period_q - PCNT_WIDTH'(1))
                      && (sub_q < limit_q);
  assign sub_last      = (sub_q + SUB_WIDTH'(1)) == limit_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values of the previous cycle regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      angle_q       <= '0;
      tick_q        <= 1'b0;
      sub_q         <= '0;
      limit_q       <= '0;
      step_period_q <= '0;
      step_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      angle_q       <= angle_d;
      tick_q        <= tick_d;
      sub_q         <= sub_d;
      limit_q       <= limit_d;
      step_period_q <= step_period_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  // Losing sync wins over everything; a tooth edge restarts from any state.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    state_d = state_q;
    if (!hwag_start) begin
      state_d = IDLE;
    end else if (tooth_edge) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (step_expire && sub_last) state_d = HOLD;
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    angle_d       = angle_q;
    tick_d        = 1'b0;
    sub_d         = sub_q;
    limit_d       = limit_q;
    step_period_d = step_period_q;
    step_cnt_d    = step_cnt_q;
    if (!hwag_start) begin
      angle_d       = '0;
      sub_d         = '0;
      limit_d       = '0;
      step_period_d = '0;
      step_cnt_d    = '0;
    end else if (tooth_edge) begin
      // A step expiring in the same cycle is dropped in favour of the new base.
      angle_d       = ANGLE_WIDTH'(base_full);
      tick_d        = 1'b1;
      sub_d         = '0;
      limit_d       = (tooth_num == TCNT_WIDTH'(GAP_TOOTH)) ? LIMIT_GAP : LIMIT_NORMAL;
      step_period_d = (period_scaled == '0) ? PCNT_WIDTH'(1) : period_scaled;
      step_cnt_d    = '0;
    end else if (step_expire) begin
      angle_d    = angle_q + ANGLE_WIDTH'(1);
      tick_d     = 1'b1;
      sub_d      = sub_q + SUB_WIDTH'(1);
      step_cnt_d = '0;
    end else if (state_q == RUN) begin
      step_cnt_d = step_cnt_q + PCNT_WIDTH'(1);
    end
  end

  always_comb begin
    angle       = angle_q;
    angle_tick  = tick_q;
    angle_valid = (state_q != IDLE);
    angle_stall = (state_q == HOLD);
  end

endmodule

// File: doc/hwag_angle_gen.md
Name: hwag_angle_gen

Overview:
- Downstream of the crank-wheel capture/sync core.
- Consumes the qualified tooth edge, the synchronised tooth number, the sync flag and the last captured tooth period.
- Interpolates STEPS = 2^STEPS_LOG2 angle steps per tooth and produces an absolute crank angle counter with a single-cycle tick on every angle change.
- Sizes the missing-tooth gap as three tooth spaces.

Parameters:
- PCNT_WIDTH, 24: width of the tooth period input (clock counts).
- TCNT_WIDTH, 6: width of the tooth number input.
- STEPS_LOG2, 6: log2 of angle steps per tooth (64).
- GAP_TOOTH, 57: tooth number whose following interval spans the gap (3 tooth spaces).
- ANGLE_WIDTH, 12: angle counter width. Must hold (GAP_TOOTH+3)*STEPS-1 = 3839.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tooth_edge  in  1  one-cycle pulse on the selected edge of each real tooth.
- hwag_start  in  1  sync-valid flag from the capture core. Low = unsynchronised.
- tooth_num  in  TCNT_WIDTH  index of the tooth whose edge this is. Valid when tooth_edge=1. Range 0..GAP_TOOTH.
- tooth_period  in  PCNT_WIDTH  last normal tooth period. Valid when tooth_edge=1.
- angle  out  ANGLE_WIDTH  current crank angle in steps.
- angle_tick  out  1  one-cycle pulse whenever angle is updated.
- angle_valid  out  1  interpolation running.
- angle_stall  out  1  step limit reached; waiting for the next edge.

Behaviour:
- Single clock. Everything is synchronous to clk. rst has priority over all other inputs.
- Reset values: angle=0, angle_tick=0, angle_valid=0, angle_stall=0. Internal step counter, step period, sub-step and limit all 0.
- hwag_start=0, regardless of other inputs: next cycle same state as after reset. No ticks.
- States:
  - IDLE: valid=0. Moves to RUN on tooth_edge & hwag_start.
  - RUN: stepping.
  - HOLD: sub-step at limit; stall=1, no ticks.
  - RUN or HOLD goes to IDLE when hwag_start=0.
  - HOLD goes back to RUN on tooth_edge.
- Tooth edge, cycle N, while hwag_start=1 (from any state). Edge has priority over a step expiry in the same cycle; the expiring step is dropped. At N+1:
  - base = tooth_num << STEPS_LOG2; angle = base; sub = 0.
  - angle_tick=1, angle_valid=1, angle_stall=0.
  - step_period = tooth_period >> STEPS_LOG2, clamped to a minimum of 1.
  - limit = 3*STEPS-1 if tooth_num == GAP_TOOTH, else STEPS-1.
  - Step counter cleared to 0.
- RUN, no edge:
  - Step counter increments each cycle.
  - When step counter == step_period-1 and sub < limit: next cycle sub+1, angle+1, angle_tick=1, step counter = 0.
  - Tick spacing is therefore exactly step_period clocks.
  - When sub == limit: go to HOLD. Step counter frozen, angle held, stall=1 from the cycle sub reaches limit.
- Early edge (acceleration): angle jumps to the new base at N+1 with one tick. Skipped steps are not emitted individually.
- Late edge (deceleration): angle holds at base+limit in HOLD until the edge.
- Wrap: angle never exceeds (GAP_TOOTH+3)*STEPS-1. An edge with tooth_num=0 restarts from 0.
- tooth_num > GAP_TOOTH: treated as a normal tooth. Angle is truncated to ANGLE_WIDTH.
- Step-period arithmetic is unsigned. No rounding: a remainder of tooth_period mod STEPS is absorbed by HOLD or by the jump.
- Mid-operation rst: next cycle reset values. The first edge after release with hwag_start=1 starts RUN.

Test Plan:
- Reset/idle: rst pulse, then edges with hwag_start=0 -> angle=0, tick=0, valid=0 throughout.
- Steady tooth: hwag_start=1, edge with tooth_num=20, period=6400, next edge 6400 clk later:
  - Tick at N+1 with angle 1280.
  - Ticks every 100 clk to 1343.
  - No stall before the next edge; next edge gives angle 1344.
- Deceleration and acceleration:
  - period=6400 but next edge after 8000 clk -> stall=1 at angle 1343 until the edge; then angle=1344 with a single tick.
  - Edge after 4000 clk -> angle jumps from 1319 to 1344 with a single tick.
- Gap and wrap:
  - Edge tooth_num=57, period=6400 -> 191 ticks at 100-clk spacing up to angle 3839; stall asserts if no edge arrives by then.
  - Edge tooth_num=0 -> angle=0.
- Edge cases:
  - period=32 -> step_period clamped to 1, tick every clk.
  - Edge coincident with a step expiry -> only the base tick is emitted.
  - hwag_start dropped mid-tooth -> next cycle angle=0, valid=0, no ticks.
  - rst asserted mid-RUN -> next cycle all outputs at reset values.
